mul_fu_scheduler: RTL and testbench
===================================

# mul_fu_scheduler

Sequencing and sharing controller for the 32-bit Wallace-tree multiplier functional unit in the Tomasulo core. Several multiply reservation stations share one multiplier. The block picks one ready station round-robin, captures its operands and tag, and holds the unit busy for a fixed latency. It then presents the 64-bit product and tag on the common data bus (CDB) and holds them until the bus grants it.

## Interface

Parameters:
- NUM_RS, 3: number of multiply reservation stations sharing the unit (2..8)
- TAG_W, 4: reservation-station tag width
- MUL_LAT, 2: execute cycles charged per multiply (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous squash of the in-flight operation
- rs_valid  in  NUM_RS  station i holds a ready multiply
- rs_a  in  32*NUM_RS  operand A of station i at bits [32i+31:32i]
- rs_b  in  32*NUM_RS  operand B, same packing
- rs_tag  in  TAG_W*NUM_RS  destination tag of station i
- rs_ack  out  NUM_RS  one-hot; station i's operands are accepted this cycle
- cdb_req  out  1  result valid, requesting the CDB
- cdb_gnt  in  1  CDB arbiter grant
- cdb_tag  out  TAG_W  tag of the broadcast result
- cdb_data  out  64  unsigned product A*B
- busy  out  1  unit not in IDLE

## Operation

- Instantiates the existing 32-bit Wallace multiplier, which is combinational, on registered operands op_a and op_b.
- States:
  - IDLE: if any rs_valid is high, select station s by round-robin. Assert rs_ack[s] combinationally this cycle. Latch rs_a[s], rs_b[s] and rs_tag[s]. Load cnt = MUL_LAT-1. Next state is EXEC. Otherwise stay in IDLE.
  - EXEC: if cnt ≠ 0, decrement it. If cnt == 0, register the multiplier output into res and the tag into res_tag. Next state is WAIT_CDB.
  - WAIT_CDB: cdb_req = 1, with cdb_data and cdb_tag driven from the registers. When cdb_gnt is sampled high, go to IDLE. Otherwise hold, with data and tag stable.
- Round-robin:
  - ptr holds the highest-priority index and resets to 0.
  - Search order is ptr, ptr+1, …, wrapping mod NUM_RS.
  - On accepting station s, ptr ← (s+1) mod NUM_RS.
- The multiply is unsigned, 32×32→64, and never truncates.
- rs_ack is asserted only in IDLE. At most one bit is set, and only for a station whose rs_valid is high.
- Stations drop rs_valid (or present a new op) in the cycle after rs_ack.
- rs_valid with cdb_gnt: cdb_gnt is ignored outside WAIT_CDB.
- A new op is never accepted in the same cycle as a grant. IDLE is always entered for at least one cycle between ops.
- flush:
  - Next state is IDLE from any state, and cnt is cleared.
  - cdb_req is low from the next cycle, and no result is broadcast.
  - ptr is unchanged, and no rs_ack is asserted in a flush cycle.
  - flush has priority over cdb_gnt in the same cycle: the result is treated as discarded.
- reset: state IDLE, ptr 0, cnt 0, op_a/op_b/res/res_tag all 0. reset overrides flush.

## Timing

- Reset values: rs_ack 0, cdb_req 0, cdb_tag 0, cdb_data 0, busy 0.
- Accept in cycle T. EXEC occupies cycles T+1 … T+MUL_LAT. cdb_req first rises in cycle T+MUL_LAT+1.
- The grant is sampled at the end of a WAIT_CDB cycle. The earliest next accept is the cycle after the grant cycle.
- Back-to-back throughput with immediate grant is one op per MUL_LAT+2 cycles.
- busy is high in EXEC and WAIT_CDB, and is a registered state decode.
- cdb_data and cdb_tag change only on entry to WAIT_CDB, so they are stable for the entire time cdb_req is high.
- A reset asserted mid-EXEC or mid-WAIT_CDB takes effect at the next edge. No result is broadcast afterwards.

## Test plan

- Single op, MUL_LAT=2: RS0 holds A=3, B=7, tag 5, and cdb_gnt is tied high. Required: rs_ack=001 in cycle T, cdb_req in T+3 with cdb_data=21 and cdb_tag=5, then IDLE in T+4.
- Width extremes: A=B=2147483643 gives 4611685996952551449. A=99999, B=999999 gives 99998900001. A=B=0xFFFFFFFF gives 0xFFFFFFFE00000001.
- Round-robin: all three stations are valid continuously, with operand pairs (13,12), (3123,732) and (13,337), and the grant is immediate. Required: acks go RS0, RS1, RS2, RS0, and results are 156, 2286036 and 4381 with matching tags.
- CDB backpressure: cdb_gnt is held low for 5 cycles while RS1 is also valid. Required: cdb_req, data and tag stay stable for all 5 cycles, and there is no rs_ack until the cycle after the grant.
- Flush: assert flush in the first EXEC cycle. Required: IDLE next cycle, no cdb_req for that op, and a subsequent op completes normally. Then assert flush together with cdb_gnt in WAIT_CDB. Required: the result is dropped.
- Reset mid-op: assert reset in WAIT_CDB. Required: all outputs read 0 next cycle, ptr is 0, and RS0 wins the next simultaneous request.

Source files
------------

// File: rtl/mul_fu_scheduler.sv
// Multiply functional-unit scheduler: round-robin pick among ready reservation
// stations, fixed-latency execute on a shared Wallace multiplier, CDB hand-off.

module wallace_mul32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_p
);

    // Carry-save reduction 32 -> 22 -> 15 -> 10 -> 7 -> 5 -> 4 -> 3 -> 2 rows,
    // then one carry-propagate add; dropped carries above bit 63 are mod 2^64.
    function automatic logic [63:0] wallace_sum(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] row [32];
        logic [63:0] nxt [32];
        int unsigned n;
        int unsigned m;
        int unsigned base;
        for (int unsigned i = 0; i < 32; i++) begin
            row[5'(i)] = b[5'(i)] ? ({32'b0, a} << i) : '0;
        end
        n = 32;
        for (int unsigned lvl = 0; lvl < 8; lvl++) begin
            m = 0;
            for (int unsigned i = 0; i < 32; i++) begin
                nxt[5'(i)] = '0;
            end
            base = (n / 3) * 3;
            for (int unsigned k = 0; k < 11; k++) begin
                if (3 * k + 2 < n) begin
                    nxt[5'(m)]     = row[5'(3*k)] ^ row[5'(3*k+1)] ^ row[5'(3*k+2)];
                    nxt[5'(m + 1)] = ((row[5'(3*k)]   & row[5'(3*k+1)]) |
                                      (row[5'(3*k)]   & row[5'(3*k+2)]) |
                                      (row[5'(3*k+1)] & row[5'(3*k+2)])) << 1;
                    m = m + 2;
                end
            end
            for (int unsigned j = 0; j < 32; j++) begin
                if (j >= base && j < n) begin
                    nxt[5'(m)] = row[5'(j)];
                    m = m + 1;
                end
            end
            row = nxt;
            n   = m;
        end
        return row[0] + row[1];
    endfunction

    assign o_p = wallace_sum(i_a, i_b);

endmodule

module mul_fu_scheduler #(
    parameter int unsigned NUM_RS  = 3,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_RS-1:0]         rs_valid,
    input  logic [32*NUM_RS-1:0]      rs_a,
    input  logic [32*NUM_RS-1:0]      rs_b,
    input  logic [TAG_W*NUM_RS-1:0]   rs_tag,
    output logic [NUM_RS-1:0]         rs_ack,
    output logic                      cdb_req,
    input  logic                      cdb_gnt,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [63:0]               cdb_data,
    output logic                      busy
);

    localparam int unsigned PTR_W = $clog2(NUM_RS);
    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_WAIT_CDB = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_busy;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [TAG_W-1:0]   r_op_tag;
    logic [63:0]        r_res;
    logic [TAG_W-1:0]   r_res_tag;

    logic [31:0]        w_a   [NUM_RS];
    logic [31:0]        w_b   [NUM_RS];
    logic [TAG_W-1:0]   w_tag [NUM_RS];
    logic               w_found;
    logic [PTR_W-1:0]   w_sel;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic               w_accept;
    logic [63:0]        w_prod;

    genvar g;
    for (g = 0; g < NUM_RS; g++) begin : g_unpack
        assign w_a[g]   = rs_a[32*g +: 32];
        assign w_b[g]   = rs_b[32*g +: 32];
        assign w_tag[g] = rs_tag[TAG_W*g +: TAG_W];
    end

    // First valid station scanning ptr, ptr+1, ... wrapping.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int unsigned k = 0; k < NUM_RS; k++) begin
            idx = PTR_W'((32'(r_ptr) + k) % NUM_RS);
            if (!w_found && rs_valid[idx]) begin
                w_found = 1'b1;
                w_sel   = idx;
            end
        end
    end

    assign w_ptr_nxt = (w_sel == PTR_W'(NUM_RS - 1)) ? '0 : w_sel + PTR_W'(1);
    assign w_accept  = (r_state == S_IDLE) && w_found && !flush && !reset;

    always_comb begin
        rs_ack = '0;
        if (w_accept) begin
            rs_ack[w_sel] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_found) w_state_nxt = S_EXEC;
            S_EXEC:     if (r_cnt == '0) w_state_nxt = S_WAIT_CDB;
            S_WAIT_CDB: if (cdb_gnt) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    wallace_mul32 u_mul (
        .i_a (r_op_a),
        .i_b (r_op_b),
        .o_p (w_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_tag  <= '0;
            r_res     <= '0;
            r_res_tag <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op_a   <= w_a[w_sel];
            r_op_b   <= w_b[w_sel];
            r_op_tag <= w_tag[w_sel];
            r_cnt    <= CNT_W'(MUL_LAT - 1);
            r_ptr    <= w_ptr_nxt;
        end else if (r_state == S_EXEC) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                r_res     <= w_prod;
                r_res_tag <= r_op_tag;
            end
        end
    end

    assign cdb_req  = (r_state == S_WAIT_CDB);
    assign cdb_data = r_res;
    assign cdb_tag  = r_res_tag;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mul_fu_scheduler.sv
// Directed bench for mul_fu_scheduler (NUM_RS=3, TAG_W=4, MUL_LAT=2).

module tb_mul_fu_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic [2:0]   rs_valid;
    logic [95:0]  rs_a;
    logic [95:0]  rs_b;
    logic [11:0]  rs_tag;
    logic [2:0]   rs_ack;
    logic         cdb_req;
    logic         cdb_gnt;
    logic [3:0]   cdb_tag;
    logic [63:0]  cdb_data;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_fu_scheduler #(
        .NUM_RS  (3),
        .TAG_W   (4),
        .MUL_LAT (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .rs_valid (rs_valid),
        .rs_a     (rs_a),
        .rs_b     (rs_b),
        .rs_tag   (rs_tag),
        .rs_ack   (rs_ack),
        .cdb_req  (cdb_req),
        .cdb_gnt  (cdb_gnt),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rs(input int i, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t);
        rs_valid[i]       = v;
        rs_a[32*i +: 32]  = a;
        rs_b[32*i +: 32]  = b;
        rs_tag[4*i +: 4]  = t;
    endtask

    // One complete op with immediate grant; starts in IDLE, ends in IDLE.
    task automatic run_op(input string tag, input int st, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t, input logic [63:0] exp);
        set_rs(st, 1'b1, a, b, t);
        cdb_gnt = 1'b1;
        #1;
        chk({tag, "_ack"}, 64'(rs_ack), 64'(1) << st);
        @(negedge clk);
        set_rs(st, 1'b0, a, b, t);
        #1;
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        chk({tag, "_noack"}, 64'(rs_ack), 64'(0));
        @(negedge clk); #1;
        chk({tag, "_req_early"}, 64'(cdb_req), 64'(0));
        @(negedge clk); #1;
        chk({tag, "_req"}, 64'(cdb_req), 64'(1));
        chk({tag, "_data"}, cdb_data, exp);
        chk({tag, "_tag"}, 64'(cdb_tag), 64'(t));
        @(negedge clk); #1;
        chk({tag, "_req_done"}, 64'(cdb_req), 64'(0));
        chk({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    int          rr_st  [4] = '{0, 1, 2, 0};
    logic [31:0] rr_a   [3] = '{32'd13, 32'd3123, 32'd13};
    logic [31:0] rr_b   [3] = '{32'd12, 32'd732, 32'd337};
    logic [63:0] rr_p   [3] = '{64'd156, 64'd2286036, 64'd4381};

    initial begin
        reset = 1'b1; flush = 1'b0; cdb_gnt = 1'b0;
        rs_valid = '0; rs_a = '0; rs_b = '0; rs_tag = '0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_ack", 64'(rs_ack), 64'(0));
        chk("rst_req", 64'(cdb_req), 64'(0));
        chk("rst_tag", 64'(cdb_tag), 64'(0));
        chk("rst_data", cdb_data, 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        run_op("single", 0, 32'd3, 32'd7, 4'd5, 64'd21);
        run_op("wide1", 0, 32'd2147483643, 32'd2147483643, 4'd1, 64'd4611685996952551449);
        run_op("wide2", 0, 32'd99999, 32'd999999, 4'd2, 64'd99998900001);
        run_op("wide3", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 64'hFFFF_FFFE_0000_0001);

        // Round-robin with all stations continuously valid
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) set_rs(i, 1'b1, rr_a[i], rr_b[i], 4'(i + 1));
        cdb_gnt = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("rr_ack", 64'(rs_ack), 64'(1) << rr_st[n]);
            @(negedge clk); #1;
            chk("rr_exec_noack", 64'(rs_ack), 64'(0));
            @(negedge clk);
            @(negedge clk); #1;
            chk("rr_req", 64'(cdb_req), 64'(1));
            chk("rr_data", cdb_data, rr_p[rr_st[n]]);
            chk("rr_tag", 64'(cdb_tag), 64'(rr_st[n] + 1));
            @(negedge clk);
            if (n == 3) rs_valid = '0;
        end
        #1;
        chk("rr_stop", 64'(rs_ack), 64'(0));

        // CDB backpressure: RS2 op, RS1 waiting
        @(negedge clk);
        cdb_gnt = 1'b0;
        set_rs(2, 1'b1, 32'd1000, 32'd1000, 4'd9);
        #1;
        chk("bp_ack", 64'(rs_ack), 64'b100);
        @(negedge clk);
        set_rs(2, 1'b0, 32'd0, 32'd0, 4'd0);
        set_rs(1, 1'b1, 32'd5, 32'd6, 4'd7);
        #1;
        chk("bp_exec_noack", 64'(rs_ack), 64'(0));
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("bp_hold_req", 64'(cdb_req), 64'(1));
            chk("bp_hold_data", cdb_data, 64'd1000000);
            chk("bp_hold_tag", 64'(cdb_tag), 64'd9);
            chk("bp_hold_noack", 64'(rs_ack), 64'(0));
        end
        @(negedge clk);
        cdb_gnt = 1'b1;
        #1;
        chk("bp_gnt_req", 64'(cdb_req), 64'(1));
        chk("bp_gnt_noack", 64'(rs_ack), 64'(0));
        @(negedge clk); #1;
        chk("bp_next_ack", 64'(rs_ack), 64'b010);
        @(negedge clk);
        set_rs(1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        @(negedge clk); #1;
        chk("bp_rs1_data", cdb_data, 64'd30);
        chk("bp_rs1_tag", 64'(cdb_tag), 64'd7);
        @(negedge clk); #1;
        chk("bp_rs1_done", 64'(cdb_req), 64'(0));

        // Flush in first EXEC cycle
        set_rs(0, 1'b1, 32'd11, 32'd11, 4'd4);
        #1;
        chk("fl_ack", 64'(rs_ack), 64'b001);
        @(negedge clk);
        set_rs(0, 1'b0, 32'd0, 32'd0, 4'd0);
        flush = 1'b1;
        #1;
        chk("fl_exec_busy", 64'(busy), 64'(1));
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_idle", 64'(busy), 64'(0));
        chk("fl_noreq0", 64'(cdb_req), 64'(0));
        @(negedge clk); #1;
        chk("fl_noreq1", 64'(cdb_req), 64'(0));
        @(negedge clk); #1;
        chk("fl_noreq2", 64'(cdb_req), 64'(0));
        run_op("fl_after", 1, 32'd20, 32'd21, 4'd6, 64'd420);

        // Flush together with grant in WAIT_CDB
        cdb_gnt = 1'b0;
        set_rs(2, 1'b1, 32'd7, 32'd8, 4'd3);
        #1;
        chk("flg_ack", 64'(rs_ack), 64'b100);
        @(negedge clk);
        set_rs(2, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        @(negedge clk); #1;
        chk("flg_req", 64'(cdb_req), 64'(1));
        chk("flg_data", cdb_data, 64'd56);
        flush = 1'b1;
        cdb_gnt = 1'b1;
        @(negedge clk);
        set_rs(0, 1'b1, 32'd2, 32'd3, 4'd1);
        #1;
        chk("flg_dropped", 64'(cdb_req), 64'(0));
        chk("flg_busy", 64'(busy), 64'(0));
        chk("flg_noack", 64'(rs_ack), 64'(0));
        @(negedge clk);
        flush = 1'b0;
        cdb_gnt = 1'b0;
        #1;
        chk("flg_next_ack", 64'(rs_ack), 64'b001);
        chk("flg_still_noreq", 64'(cdb_req), 64'(0));

        // Reset mid-WAIT_CDB
        @(negedge clk);
        set_rs(0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        @(negedge clk); #1;
        chk("rm_req", 64'(cdb_req), 64'(1));
        chk("rm_data", cdb_data, 64'd6);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("rm_ack0", 64'(rs_ack), 64'(0));
        chk("rm_req0", 64'(cdb_req), 64'(0));
        chk("rm_tag0", 64'(cdb_tag), 64'(0));
        chk("rm_data0", cdb_data, 64'(0));
        chk("rm_busy0", 64'(busy), 64'(0));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) set_rs(i, 1'b1, rr_a[i], rr_b[i], 4'(i + 1));
        #1;
        chk("rm_ptr0_ack", 64'(rs_ack), 64'b001);
        @(negedge clk);
        rs_valid = '0;
        #1;
        chk("rm_busy_after", 64'(busy), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
